// File: rtl/win3x3_gen.sv
// Streaming 3x3 window generator: two column-indexed line buffers plus a
// three-column shift register, feeding the median-of-3 stage downstream.
module win3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    pix_vld,
    input  logic [DATA_WIDTH-1:0]   pix_in,
    output logic [9*DATA_WIDTH-1:0] win,
    output logic                    win_vld,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int DW = DATA_WIDTH;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]   col_cnt_q, col_cnt_d, pos_col;
    logic [RW-1:0]   row_cnt_q, row_cnt_d, pos_row;
    logic [3*DW-1:0] c0_q, c1_q, c2_q, c0_d, c1_d, c2_d, new_col;
    logic            win_vld_q, win_vld_d;
    logic            frame_done_q, frame_done_d;

    // Line buffers are never reset; rows 0 and 1 of a frame gate them out.
    logic [DW-1:0] lb0_q [0:IMG_WIDTH-1];
    logic [DW-1:0] lb1_q [0:IMG_WIDTH-1];

    always_comb begin
        pos_col      = frame_start ? '0 : col_cnt_q;
        pos_row      = frame_start ? '0 : row_cnt_q;
        new_col      = {lb1_q[pos_col], lb0_q[pos_col], pix_in};
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        c0_d         = c0_q;
        c1_d         = c1_q;
        c2_d         = c2_q;
        win_vld_d    = 1'b0;
        frame_done_d = 1'b0;
        if (pix_vld) begin
            c0_d = c1_q;
            c1_d = c2_q;
            c2_d = new_col;
            if (pos_col == COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                col_cnt_d = pos_col + CW'(1);
                row_cnt_d = pos_row;
            end
            win_vld_d    = (pos_row >= RW'(2)) && (pos_col >= CW'(2));
            frame_done_d = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            c0_q         <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            c0_q         <= c0_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            win_vld_q    <= win_vld_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_vld) begin
            lb1_q[pos_col] <= lb0_q[pos_col];
            lb0_q[pos_col] <= pix_in;
        end
    end

    // Each column register is packed {top, mid, bottom}; win is row-major.
    assign win = {c0_q[3*DW-1 -: DW], c1_q[3*DW-1 -: DW], c2_q[3*DW-1 -: DW],
                  c0_q[2*DW-1 -: DW], c1_q[2*DW-1 -: DW], c2_q[2*DW-1 -: DW],
                  c0_q[DW-1 -: DW],   c1_q[DW-1 -: DW],   c2_q[DW-1 -: DW]};
    assign win_vld    = win_vld_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_win3x3_gen.sv
// Directed bench for win3x3_gen on a 4x3 frame with pixel = 16*r + c + offset.
module tb_win3x3_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          pix_vld;
    logic [DW-1:0] pix_in;
    logic [9*DW-1:0] win;
    logic          win_vld;
    logic          frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    win3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_vld(pix_vld),
        .pix_in(pix_in), .win(win), .win_vld(win_vld), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c, input int off);
        return DW'(16 * r + c + off);
    endfunction

    function automatic logic [9*DW-1:0] exp_win(input int r, input int c, input int off);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[9*DW-1-DW*(3*i+j) -: DW] = pix(r - 2 + i, c - 2 + j, off);
        return w;
    endfunction

    // One accepted beat; outputs are sampled 1 time unit after the edge.
    task automatic beat(input logic [DW-1:0] p, input logic fs);
        pix_vld     = 1'b1;
        pix_in      = p;
        frame_start = fs;
        @(posedge clk);
        #1;
        pix_vld     = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk("gap_vld", 72'(win_vld), 72'(0));
            chk("gap_done", 72'(frame_done), 72'(0));
        end
    endtask

    // Streams rows 0..last_r fully plus columns 0..last_c of the final row.
    task automatic frame(input logic fs, input int gap, input int off,
                         input int last_r, input int last_c);
        logic ev;
        for (int r = 0; r <= last_r; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == last_r && c > last_c) break;
                beat(pix(r, c, off), fs && r == 0 && c == 0);
                ev = (r >= 2) && (c >= 2);
                chk("win_vld", 72'(win_vld), 72'(ev));
                chk("frame_done", 72'(frame_done), 72'(r == H - 1 && c == W - 1));
                if (ev) chk("win", win, exp_win(r, c, off));
                if (gap > 0) idle(gap);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pix_vld = 1'b0; pix_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win", win, 72'(0));
        chk("rst_vld", 72'(win_vld), 72'(0));
        chk("rst_done", 72'(frame_done), 72'(0));
        #2 rst_n = 1'b1;

        // basic frame, then same frame with gaps (frame_start meets a wrap)
        frame(1'b1, 0, 8'h00, H - 1, W - 1);
        idle(1);
        frame(1'b1, 3, 8'h40, H - 1, W - 1);

        // two back-to-back frames, frame_start only on the first
        frame(1'b1, 0, 8'h80, H - 1, W - 1);
        frame(1'b0, 0, 8'h08, H - 1, W - 1);

        // partial old frame up to (1,1), then resync at old position (1,2)
        frame(1'b1, 0, 8'hA0, 1, 1);
        frame(1'b1, 0, 8'h50, H - 1, W - 1);

        // async reset mid-row 2 while a window is valid
        frame(1'b1, 0, 8'h30, 2, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_win", win, 72'(0));
        chk("arst_vld", 72'(win_vld), 72'(0));
        chk("arst_done", 72'(frame_done), 72'(0));
        #3 rst_n = 1'b1;
        idle(1);
        frame(1'b0, 0, 8'h60, H - 1, W - 1);

        // async reset while frame_done is high
        #2 rst_n = 1'b0;
        #1;
        chk("arst_done2", 72'(frame_done), 72'(0));
        #3 rst_n = 1'b1;
        frame(1'b0, 1, 8'h70, H - 1, W - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
